// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between a capture-side writer and a display-side reader.
// Reads take priority, but a pending write is forced through after RD_MAX_CONSEC consecutive read grants.
module sram_arbiter #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int RD_MAX_CONSEC = 4
) (
    input  logic              sysClk,
    input  logic              reset,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrAck,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdAck,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic [ADDR_W-1:0] SRAM_A,
    inout  wire  [DATA_W-1:0] SRAM_D,
    output logic              SRAM_nCS,
    output logic              SRAM_nOE,
    output logic              SRAM_nWE,
    output logic              busy
);
    localparam int CNT_W = $clog2(RD_MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_MAX_CONSEC);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE1, WR_PULSE2, WR_HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_win, drive;

    assign wr_win = wrReq && (!rdReq || starve_cnt == CNT_MAX);

    // Acks are decoded straight from the granting IDLE cycle; reset masks them.
    always_comb begin
        state_nxt = state;
        rdAck     = 1'b0;
        wrAck     = 1'b0;
        case (state)
            IDLE: begin
                rdAck     = !reset && rdReq && !wr_win;
                wrAck     = !reset && wr_win;
                state_nxt = rdAck ? RD_ADDR : wrAck ? WR_SETUP : IDLE;
            end
            RD_ADDR:   state_nxt = RD_WAIT;
            RD_WAIT:   state_nxt = RD_LATCH;
            WR_SETUP:  state_nxt = WR_PULSE1;
            WR_PULSE1: state_nxt = WR_PULSE2;
            WR_PULSE2: state_nxt = WR_HOLD;
            default:   state_nxt = IDLE;
        endcase
    end

    assign busy     = state != IDLE;
    assign SRAM_nCS = !busy;
    assign SRAM_nOE = !(state inside {RD_ADDR, RD_WAIT, RD_LATCH});
    assign SRAM_nWE = !(state inside {WR_PULSE1, WR_PULSE2});
    assign drive    = state inside {WR_SETUP, WR_PULSE1, WR_PULSE2, WR_HOLD};
    assign SRAM_D   = drive ? wr_data_q : 'z;

    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            SRAM_A     <= '0;
            wr_data_q  <= '0;
            rdData     <= '0;
            rdValid    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rdValid <= state == RD_LATCH;
            if (state == RD_LATCH)
                rdData <= SRAM_D;
            if (rdAck)
                SRAM_A <= rdAddr;
            if (wrAck) begin
                SRAM_A    <= wrAddr;
                wr_data_q <= wrData;
            end
            // Counts reads that overtook a waiting write; any idle moment without a writer forgets them.
            if (wrAck)
                starve_cnt <= '0;
            else if (rdAck && wrReq)
                starve_cnt <= starve_cnt == CNT_MAX ? CNT_MAX : starve_cnt + 1'b1;
            else if (state == IDLE && !wrReq)
                starve_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: drives the arbiter against a pin-level SRAM model and a transaction-level reference.
module tb_sram_arbiter;
    localparam int RD_MAX = 4;

    logic        sysClk = 1'b0;
    logic        reset, wrReq, rdReq;
    logic [17:0] wrAddr, rdAddr;
    logic [15:0] wrData;
    logic        wrAck, rdAck, rdValid, busy;
    logic [15:0] rdData;
    logic [17:0] SRAM_A;
    wire  [15:0] sram_d;
    logic        SRAM_nCS, SRAM_nOE, SRAM_nWE;

    int tests = 0;
    int fails = 0;

    sram_arbiter dut (
        .sysClk(sysClk), .reset(reset),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrAck(wrAck),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdAck(rdAck), .rdData(rdData), .rdValid(rdValid),
        .SRAM_A(SRAM_A), .SRAM_D(sram_d),
        .SRAM_nCS(SRAM_nCS), .SRAM_nOE(SRAM_nOE), .SRAM_nWE(SRAM_nWE), .busy(busy)
    );

    always #5 sysClk = ~sysClk;

    // Undriven bus floats to all ones so a released bus is observable.
    pullup (sram_d);

    // SRAM model: unwritten cells hold a fixed pattern, 0x00123 holds 0xBEEF.
    logic [15:0] mem [0:262143];
    bit          written [0:262143];
    logic [15:0] sram_q;

    function automatic logic [15:0] pat(input logic [17:0] a);
        return a == 18'h00123 ? 16'hBEEF : a[15:0] ^ 16'h5A5A;
    endfunction

    always_comb sram_q = written[SRAM_A] ? mem[SRAM_A] : pat(SRAM_A);
    assign sram_d = (!SRAM_nCS && !SRAM_nOE) ? sram_q : 'z;

    always @(posedge sysClk)
        if (!SRAM_nCS && !SRAM_nWE) begin
            mem[SRAM_A]     <= sram_d;
            written[SRAM_A] <= 1'b1;
        end

    always @(negedge sysClk) begin
        tests++;
        if (!SRAM_nOE && !SRAM_nWE) begin
            fails++;
            $display("FAIL strobe_overlap nOE=%b nWE=%b, want never both low", SRAM_nOE, SRAM_nWE);
        end
        tests++;
        if (busy !== !SRAM_nCS) begin
            fails++;
            $display("FAIL busy_vs_ncs busy=%b nCS=%b, want busy high exactly when selected", busy, SRAM_nCS);
        end
    end

    logic [15:0] ref_mem [logic [17:0]];

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic test_reset();
        #3 rdReq = 1'b1;
        #1;
        tests++;
        if ({SRAM_nCS, SRAM_nOE, SRAM_nWE, rdAck, wrAck, rdValid, busy} !== 7'b1110000 ||
            SRAM_A !== 18'h0 || rdData !== 16'h0 || sram_d !== 16'hFFFF) begin
            fails++;
            $display("FAIL reset_state strobes/acks=%b A=%h rdData=%h D=%h, want 1110000 A=0 rdData=0 D=ffff",
                     {SRAM_nCS, SRAM_nOE, SRAM_nWE, rdAck, wrAck, rdValid, busy}, SRAM_A, rdData, sram_d);
        end
        repeat (2) @(posedge sysClk);
        #1 reset = 1'b0;
        @(negedge sysClk);
        tests++;
        if (rdAck !== 1'b1) begin
            fails++;
            $display("FAIL first_grant rdAck=%b, want 1", rdAck);
        end
        @(posedge sysClk);
        #1 rdReq = 1'b0;
        @(negedge sysClk);
        tests++;
        if (busy !== 1'b1 || SRAM_nOE !== 1'b0) begin
            fails++;
            $display("FAIL first_grant_busy busy=%b nOE=%b, want 1 0", busy, SRAM_nOE);
        end
        repeat (6) @(posedge sysClk);
    endtask

    task automatic test_read();
        logic [5:1]  noe_v, val_v, ack_v;
        logic [15:0] data;
        logic [17:0] addr;
        @(posedge sysClk);
        #1 rdReq = 1'b1;
        rdAddr = 18'h00123;
        @(negedge sysClk);
        tests++;
        if (rdAck !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL read_ack rdAck=%b busy=%b, want 1 0", rdAck, busy);
        end
        @(posedge sysClk);
        #1 rdReq = 1'b0;
        data = 'x;
        addr = 'x;
        for (int k = 1; k <= 5; k++) begin
            @(negedge sysClk);
            noe_v[k] = SRAM_nOE;
            val_v[k] = rdValid;
            ack_v[k] = rdAck;
            if (k == 2) addr = SRAM_A;
            if (k == 4) data = rdData;
        end
        tests++;
        if (noe_v !== 5'b11000) begin
            fails++;
            $display("FAIL read_noe cycles1-5=%b, want 11000", noe_v);
        end
        tests++;
        if (val_v !== 5'b01000 || ack_v !== 5'b00000) begin
            fails++;
            $display("FAIL read_valid valid=%b ack=%b, want 01000 00000", val_v, ack_v);
        end
        tests++;
        if (data !== 16'hBEEF || addr !== 18'h00123) begin
            fails++;
            $display("FAIL read_data data=%h addr=%h, want beef 00123", data, addr);
        end
    endtask

    task automatic test_write();
        logic [6:1] nwe_v, busy_v, drv_v, noe_v;
        logic [15:0] d_idle;
        @(posedge sysClk);
        #1 wrReq = 1'b1;
        wrAddr = 18'h3FFFF;
        wrData = 16'hA5A5;
        @(negedge sysClk);
        tests++;
        if (wrAck !== 1'b1 || rdAck !== 1'b0) begin
            fails++;
            $display("FAIL write_ack wrAck=%b rdAck=%b, want 1 0", wrAck, rdAck);
        end
        @(posedge sysClk);
        #1 wrReq = 1'b0;
        d_idle = 'x;
        for (int k = 1; k <= 6; k++) begin
            @(negedge sysClk);
            nwe_v[k]  = SRAM_nWE;
            noe_v[k]  = SRAM_nOE;
            busy_v[k] = busy;
            drv_v[k]  = sram_d === 16'hA5A5;
            if (k == 5) d_idle = sram_d;
        end
        tests++;
        if (nwe_v !== 6'b111001 || noe_v !== 6'b111111) begin
            fails++;
            $display("FAIL write_strobes nWE=%b nOE=%b, want 111001 111111", nwe_v, noe_v);
        end
        tests++;
        if (busy_v !== 6'b001111 || drv_v !== 6'b001111) begin
            fails++;
            $display("FAIL write_window busy=%b driven=%b, want 001111 001111", busy_v, drv_v);
        end
        tests++;
        if (d_idle !== 16'hFFFF) begin
            fails++;
            $display("FAIL write_release D=%h in idle, want ffff (floating)", d_idle);
        end
        tests++;
        if (!written[18'h3FFFF] || mem[18'h3FFFF] !== 16'hA5A5) begin
            fails++;
            $display("FAIL write_mem written=%b mem=%h, want 1 a5a5", written[18'h3FFFF], mem[18'h3FFFF]);
        end
    endtask

    task automatic test_starvation();
        string got = "";
        string want = "";
        int    at[$];
        int    cnt = 0;
        int    exp_at = 0;
        for (int i = 0; i < 10; i++) begin
            if (cnt == RD_MAX) begin
                want = {want, "W"};
                cnt = 0;
            end else begin
                want = {want, "R"};
                cnt++;
            end
        end
        @(posedge sysClk);
        #1 rdReq = 1'b1;
        wrReq  = 1'b1;
        rdAddr = 18'h00200;
        wrAddr = 18'h00300;
        wrData = 16'h1234;
        for (int c = 0; c < 80 && got.len() < 10; c++) begin
            @(negedge sysClk);
            if (rdAck) begin
                got = {got, "R"};
                at.push_back(c);
            end
            if (wrAck) begin
                got = {got, "W"};
                at.push_back(c);
            end
            @(posedge sysClk);
            #1;
        end
        rdReq = 1'b0;
        wrReq = 1'b0;
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL starve_order got %s, want %s", got, want);
        end
        for (int i = 0; i < at.size() && i < 10; i++) begin
            tests++;
            if (at[i] != exp_at) begin
                fails++;
                $display("FAIL starve_timing grant %0d at cycle %0d, want %0d", i, at[i], exp_at);
            end
            exp_at += (want[i] == "W") ? 5 : 4;
        end
        repeat (8) @(posedge sysClk);
    endtask

    task automatic test_midread_pulse();
        int racks = 0;
        int wacks = 0;
        int nwe = 0;
        int vals = 0;
        logic [15:0] data = 'x;
        for (int c = 0; c < 14; c++) begin
            @(posedge sysClk);
            #1;
            if (c == 0) begin
                rdReq  = 1'b1;
                rdAddr = 18'h00101;
            end
            if (c == 1) rdReq = 1'b0;
            if (c == 2) begin
                wrReq  = 1'b1;
                wrAddr = 18'h00105;
                wrData = 16'hDEAD;
            end
            if (c == 3) wrReq = 1'b0;
            @(negedge sysClk);
            racks += int'(rdAck);
            wacks += int'(wrAck);
            nwe   += int'(!SRAM_nWE);
            if (rdValid) begin
                vals++;
                data = rdData;
            end
        end
        tests++;
        if (racks != 1 || wacks != 0 || nwe != 0) begin
            fails++;
            $display("FAIL pulse_ignored rdAcks=%0d wrAcks=%0d nWE_low=%0d, want 1 0 0", racks, wacks, nwe);
        end
        tests++;
        if (vals != 1 || data !== pat(18'h00101) || written[18'h00105]) begin
            fails++;
            $display("FAIL pulse_read valids=%0d data=%h written105=%b, want 1 %h 0",
                     vals, data, written[18'h00105], pat(18'h00101));
        end
    endtask

    task automatic test_random();
        int          cnt = 0;
        int          free_at = 0;
        int          vq_c[$];
        logic [15:0] vq_d[$];
        logic        rd_p = 1'b0;
        logic        wr_p = 1'b0;
        logic        idle, exp_ra, exp_wa, exp_v;
        logic [17:0] ra = '0;
        logic [17:0] wa = '0;
        logic [15:0] wd = '0;
        logic [15:0] vd = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge sysClk);
            #1;
            if (!rd_p && $urandom_range(0, 2) == 0) begin
                rd_p = 1'b1;
                ra   = 18'h00100 + 18'($urandom_range(0, 7));
            end
            if (!wr_p && $urandom_range(0, 3) == 0) begin
                wr_p = 1'b1;
                wa   = 18'h00100 + 18'($urandom_range(0, 7));
                wd   = 16'($urandom);
            end
            rdReq  = rd_p;
            rdAddr = ra;
            wrReq  = wr_p;
            wrAddr = wa;
            wrData = wd;
            idle   = c >= free_at;
            exp_wa = idle && wr_p && (!rd_p || cnt == RD_MAX);
            exp_ra = idle && rd_p && !exp_wa;
            if (exp_wa) begin
                cnt = 0;
                free_at = c + 5;
                ref_mem[wa] = wd;
            end else if (exp_ra) begin
                cnt = wr_p ? (cnt < RD_MAX ? cnt + 1 : RD_MAX) : 0;
                free_at = c + 4;
                vq_c.push_back(c + 4);
                vq_d.push_back(ref_rd(ra));
            end else if (idle && !wr_p) begin
                cnt = 0;
            end
            exp_v = vq_c.size() > 0 && vq_c[0] == c;
            if (exp_v) begin
                vd = vq_d[0];
                void'(vq_c.pop_front());
                void'(vq_d.pop_front());
            end
            @(negedge sysClk);
            tests++;
            if ({rdAck, wrAck, busy} !== {exp_ra, exp_wa, !idle}) begin
                fails++;
                $display("FAIL rand_grant cycle %0d rdAck/wrAck/busy=%b, want %b",
                         c, {rdAck, wrAck, busy}, {exp_ra, exp_wa, !idle});
            end
            tests++;
            if (rdValid !== exp_v || (exp_v && rdData !== vd)) begin
                fails++;
                $display("FAIL rand_read cycle %0d rdValid=%b rdData=%h, want %b %h", c, rdValid, rdData, exp_v, vd);
            end
            if (exp_ra) rd_p = 1'b0;
            if (exp_wa) wr_p = 1'b0;
        end
        @(posedge sysClk);
        #1 rdReq = 1'b0;
        wrReq = 1'b0;
        repeat (8) @(posedge sysClk);
    endtask

    task automatic test_reset_midwrite();
        int acks = 0;
        int busys = 0;
        @(posedge sysClk);
        #1 wrReq = 1'b1;
        wrAddr = 18'h00400;
        wrData = 16'h0F0F;
        @(negedge sysClk);
        tests++;
        if (wrAck !== 1'b1) begin
            fails++;
            $display("FAIL abort_ack wrAck=%b, want 1", wrAck);
        end
        @(posedge sysClk);
        #1 wrReq = 1'b0;
        @(posedge sysClk);
        @(negedge sysClk);
        tests++;
        if (SRAM_nWE !== 1'b0) begin
            fails++;
            $display("FAIL abort_pulse nWE=%b in first pulse cycle, want 0", SRAM_nWE);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if ({SRAM_nCS, SRAM_nOE, SRAM_nWE, busy, wrAck} !== 5'b11100 || sram_d !== 16'hFFFF || SRAM_A !== 18'h0) begin
            fails++;
            $display("FAIL abort_now strobes/busy/ack=%b D=%h A=%h, want 11100 ffff 0",
                     {SRAM_nCS, SRAM_nOE, SRAM_nWE, busy, wrAck}, sram_d, SRAM_A);
        end
        @(posedge sysClk);
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sysClk);
            acks  += int'(wrAck || rdAck || rdValid);
            busys += int'(busy);
        end
        tests++;
        if (acks != 0 || busys != 0) begin
            fails++;
            $display("FAIL abort_after acks/valids=%0d busy_cycles=%0d, want 0 0", acks, busys);
        end
    endtask

    initial begin
        reset  = 1'b1;
        rdReq  = 1'b0;
        wrReq  = 1'b0;
        rdAddr = '0;
        wrAddr = '0;
        wrData = '0;
        test_reset();
        test_read();
        test_write();
        test_starvation();
        test_midread_pulse();
        test_random();
        test_reset_midwrite();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish by %0t", $time);
        $fatal(1);
    end
endmodule
